// File: rtl/hit_merge_fifo_if.sv
// Upstream (R18) and downstream (R19) hit handshake bundle for hit_merge_fifo.
// The slave modport is the FIFO's view; the master modport is the surrounding pipeline's view.
interface hit_merge_fifo_if #(
  parameter int SIGFIG = 24,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic signed [1:0][AXIS-1:0][SIGFIG-1:0]   hit_R18S;
  logic        [1:0][COLORS-1:0][SIGFIG-1:0] color_R18U;
  logic        [1:0]                         hit_valid_R18H;
  logic                                      halt_RnnnnL;
  logic signed [AXIS-1:0][SIGFIG-1:0]        hit_R19S;
  logic        [COLORS-1:0][SIGFIG-1:0]      color_R19U;
  logic                                      hit_valid_R19H;
  logic                                      out_ready_R19H;
  logic        [CW-1:0]                      occupancy;

  modport slave (
    input  hit_R18S, color_R18U, hit_valid_R18H, out_ready_R19H,
    output halt_RnnnnL, hit_R19S, color_R19U, hit_valid_R19H, occupancy
  );

  modport master (
    output hit_R18S, color_R18U, hit_valid_R18H, out_ready_R19H,
    input  halt_RnnnnL, hit_R19S, color_R19U, hit_valid_R19H, occupancy
  );
endinterface

// File: rtl/hit_merge_fifo.sv
// Two-lane in, one-lane out hit FIFO between the dual-sample test stage and the framebuffer stage.
// Upstream is halted whenever fewer than two free slots remain, so a push can never overflow.
module hit_merge_fifo #(
  parameter int SIGFIG = 24,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  hit_merge_fifo_if.slave        bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AXIS-1:0][SIGFIG-1:0]   r_mem_hit [DEPTH];
  logic [COLORS-1:0][SIGFIG-1:0] r_mem_col [DEPTH];
  logic [PW-1:0]                 r_wp;
  logic [PW-1:0]                 r_rp;
  logic [CW-1:0]                 r_cnt;

  logic          w_halt_n;
  logic          w_push0;
  logic          w_push1;
  logic [1:0]    w_n_in;
  logic          w_pop;
  logic [PW-1:0] w_wp_lane1;

  // Halt depends only on the registered count, never on out_ready.
  assign w_halt_n   = (r_cnt <= CW'(DEPTH - 2));
  assign w_push0    = w_halt_n & bus.hit_valid_R18H[0];
  assign w_push1    = w_halt_n & bus.hit_valid_R18H[1];
  assign w_n_in     = {1'b0, w_push0} + {1'b0, w_push1};
  assign w_pop      = (r_cnt != '0) & bus.out_ready_R19H;
  assign w_wp_lane1 = w_push0 ? r_wp + PW'(1) : r_wp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + PW'(w_n_in);
      r_rp  <= r_rp + PW'(w_pop);
      r_cnt <= r_cnt + CW'(w_n_in) - CW'(w_pop);
    end
  end

  // Storage is deliberately not reset; valid is derived from r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_mem_hit[r_wp] <= bus.hit_R18S[0];
      r_mem_col[r_wp] <= bus.color_R18U[0];
    end
    if (w_push1) begin
      r_mem_hit[w_wp_lane1] <= bus.hit_R18S[1];
      r_mem_col[w_wp_lane1] <= bus.color_R18U[1];
    end
  end

  assign bus.halt_RnnnnL    = w_halt_n;
  assign bus.hit_valid_R19H = (r_cnt != '0);
  assign bus.hit_R19S       = r_mem_hit[r_rp];
  assign bus.color_R19U     = r_mem_col[r_rp];
  assign bus.occupancy      = r_cnt;

  a_cnt_range : assert property (@(posedge clk) disable iff (!rst) r_cnt <= CW'(DEPTH));
endmodule

// File: tb/tb_hit_merge_fifo.sv
// Directed bench for hit_merge_fifo: reset, lane ordering, fill/halt boundaries, wrap and idle lanes.
module tb_hit_merge_fifo;
  localparam int SIGFIG = 24;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hit_merge_fifo_if #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH)) bus ();

  hit_merge_fifo #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane x is carried on axis 0; color channel 0 is x xor a fixed pattern so color routing is checked too.
  task automatic drive_in(input logic [1:0] v, input logic [23:0] x0, input logic [23:0] x1);
    bus.hit_valid_R18H    = v;
    bus.hit_R18S          = '0;
    bus.color_R18U        = '0;
    bus.hit_R18S[0][0]    = x0;
    bus.hit_R18S[1][0]    = x1;
    bus.hit_R18S[0][2]    = ~x0;
    bus.hit_R18S[1][2]    = ~x1;
    bus.color_R18U[0][0]  = x0 ^ 24'hABCDEF;
    bus.color_R18U[1][0]  = x1 ^ 24'hABCDEF;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.out_ready_R19H = 1'b0;
    drive_in(2'b00, 24'h0, 24'h0);
    #12;
    total++; if (bus.hit_valid_R19H !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.hit_valid_R19H); end
    total++; if (bus.occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
    total++; if (bus.halt_RnnnnL !== 1'b1) begin bad++; $display("FAIL reset_halt got=%b exp=1", bus.halt_RnnnnL); end
    rst = 1'b1;
    tick();
    // Fill to 5 then reset mid-stream.
    drive_in(2'b11, 24'h1, 24'h2); tick();
    drive_in(2'b11, 24'h3, 24'h4); tick();
    drive_in(2'b01, 24'h5, 24'h0); tick();
    drive_in(2'b00, 24'h0, 24'h0);
    total++; if (bus.occupancy !== 4'd5) begin bad++; $display("FAIL prereset_occ got=%0d exp=5", bus.occupancy); end
    #2 rst = 1'b0;
    #1;
    total++; if (bus.hit_valid_R19H !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", bus.hit_valid_R19H); end
    total++; if (bus.occupancy !== 4'd0) begin bad++; $display("FAIL midreset_occ got=%0d exp=0", bus.occupancy); end
    total++; if (bus.halt_RnnnnL !== 1'b1) begin bad++; $display("FAIL midreset_halt got=%b exp=1", bus.halt_RnnnnL); end
    #2 rst = 1'b1;
    tick();
    bus.out_ready_R19H = 1'b1;
    drive_in(2'b01, 24'h77, 24'h0);
    tick();
    drive_in(2'b00, 24'h0, 24'h0);
    total++; if (bus.hit_valid_R19H !== 1'b1) begin bad++; $display("FAIL postreset_valid got=%b exp=1", bus.hit_valid_R19H); end
    total++; if (bus.hit_R19S[0] !== 24'h77) begin bad++; $display("FAIL postreset_x got=%0h exp=77", bus.hit_R19S[0]); end
    total++; if (bus.occupancy !== 4'd1) begin bad++; $display("FAIL postreset_occ got=%0d exp=1", bus.occupancy); end
    tick();
    total++; if (bus.hit_valid_R19H !== 1'b0) begin bad++; $display("FAIL postreset_drain got=%b exp=0", bus.hit_valid_R19H); end
  endtask

  task automatic test_dual_order();
    bus.out_ready_R19H = 1'b1;
    drive_in(2'b11, 24'h10, 24'h20);
    total++; if (bus.hit_valid_R19H !== 1'b0) begin bad++; $display("FAIL order_nobypass got=%b exp=0", bus.hit_valid_R19H); end
    tick();
    drive_in(2'b10, 24'h0, 24'h30);
    total++; if (bus.hit_R19S[0] !== 24'h10 || bus.hit_valid_R19H !== 1'b1) begin bad++; $display("FAIL order_0 got=%0h/%b exp=10/1", bus.hit_R19S[0], bus.hit_valid_R19H); end
    total++; if (bus.color_R19U[0] !== (24'h10 ^ 24'hABCDEF)) begin bad++; $display("FAIL order_color0 got=%0h exp=%0h", bus.color_R19U[0], 24'h10 ^ 24'hABCDEF); end
    tick();
    drive_in(2'b00, 24'h0, 24'h0);
    total++; if (bus.hit_R19S[0] !== 24'h20 || bus.hit_valid_R19H !== 1'b1) begin bad++; $display("FAIL order_1 got=%0h/%b exp=20/1", bus.hit_R19S[0], bus.hit_valid_R19H); end
    total++; if (bus.hit_R19S[2] !== ~24'h20) begin bad++; $display("FAIL order_z1 got=%0h exp=%0h", bus.hit_R19S[2], ~24'h20); end
    tick();
    total++; if (bus.hit_R19S[0] !== 24'h30 || bus.hit_valid_R19H !== 1'b1) begin bad++; $display("FAIL order_2 got=%0h/%b exp=30/1", bus.hit_R19S[0], bus.hit_valid_R19H); end
    tick();
    total++; if (bus.hit_valid_R19H !== 1'b0 || bus.occupancy !== 4'd0) begin bad++; $display("FAIL order_empty got=%b/%0d exp=0/0", bus.hit_valid_R19H, bus.occupancy); end
  endtask

  task automatic test_fill_halt();
    logic [23:0] exp_q[$];
    bus.out_ready_R19H = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_in(2'b11, 24'(2*k+1), 24'(2*k+2));
      total++; if (bus.halt_RnnnnL !== 1'b1) begin bad++; $display("FAIL fill_halt_pre%0d got=%b exp=1", k, bus.halt_RnnnnL); end
      exp_q.push_back(24'(2*k+1));
      exp_q.push_back(24'(2*k+2));
      tick();
      total++; if (bus.occupancy !== 4'(2*k+2)) begin bad++; $display("FAIL fill_occ%0d got=%0d exp=%0d", k, bus.occupancy, 2*k+2); end
    end
    total++; if (bus.halt_RnnnnL !== 1'b0) begin bad++; $display("FAIL fill_halt_full got=%b exp=0", bus.halt_RnnnnL); end
    drive_in(2'b11, 24'hE0, 24'hE1);
    tick(); tick();
    total++; if (bus.occupancy !== 4'd8) begin bad++; $display("FAIL fill_held got=%0d exp=8", bus.occupancy); end
    drive_in(2'b00, 24'h0, 24'h0);
    bus.out_ready_R19H = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.hit_R19S[0] !== exp_q[i]) begin bad++; $display("FAIL fill_drain%0d got=%0h exp=%0h", i, bus.hit_R19S[0], exp_q[i]); end
      tick();
    end
    total++; if (bus.hit_valid_R19H !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", bus.hit_valid_R19H); end
  endtask

  task automatic test_boundary7();
    logic [23:0] exp_q[$];
    bus.out_ready_R19H = 1'b0;
    drive_in(2'b11, 24'h1, 24'h2); tick();
    drive_in(2'b11, 24'h3, 24'h4); tick();
    drive_in(2'b11, 24'h5, 24'h6); tick();
    drive_in(2'b01, 24'h7, 24'h0); tick();
    exp_q = '{24'h2, 24'h3, 24'h4, 24'h5, 24'h6, 24'h7, 24'hA1, 24'hA2};
    total++; if (bus.occupancy !== 4'd7) begin bad++; $display("FAIL b7_occ got=%0d exp=7", bus.occupancy); end
    total++; if (bus.halt_RnnnnL !== 1'b0) begin bad++; $display("FAIL b7_halt got=%b exp=0", bus.halt_RnnnnL); end
    drive_in(2'b11, 24'hA1, 24'hA2);
    bus.out_ready_R19H = 1'b1;
    total++; if (bus.halt_RnnnnL !== 1'b0) begin bad++; $display("FAIL b7_halt_pop got=%b exp=0", bus.halt_RnnnnL); end
    tick();
    bus.out_ready_R19H = 1'b0;
    total++; if (bus.occupancy !== 4'd6 || bus.halt_RnnnnL !== 1'b1) begin bad++; $display("FAIL b7_after_pop got=%0d/%b exp=6/1", bus.occupancy, bus.halt_RnnnnL); end
    tick();
    drive_in(2'b00, 24'h0, 24'h0);
    total++; if (bus.occupancy !== 4'd8) begin bad++; $display("FAIL b7_refill got=%0d exp=8", bus.occupancy); end
    bus.out_ready_R19H = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.hit_R19S[0] !== exp_q[i]) begin bad++; $display("FAIL b7_drain%0d got=%0h exp=%0h", i, bus.hit_R19S[0], exp_q[i]); end
      tick();
    end
    total++; if (bus.hit_valid_R19H !== 1'b0) begin bad++; $display("FAIL b7_empty got=%b exp=0", bus.hit_valid_R19H); end
  endtask

  task automatic test_simul_wrap();
    logic [23:0] q[$];
    bus.out_ready_R19H = 1'b0;
    drive_in(2'b11, 24'h101, 24'h102); q.push_back(24'h101); q.push_back(24'h102); tick();
    drive_in(2'b01, 24'h103, 24'h0);   q.push_back(24'h103); tick();
    total++; if (bus.occupancy !== 4'd3) begin bad++; $display("FAIL sim_occ3 got=%0d exp=3", bus.occupancy); end
    bus.out_ready_R19H = 1'b1;
    drive_in(2'b11, 24'h104, 24'h105); q.push_back(24'h104); q.push_back(24'h105);
    total++; if (bus.hit_R19S[0] !== q[0]) begin bad++; $display("FAIL sim_head0 got=%0h exp=%0h", bus.hit_R19S[0], q[0]); end
    void'(q.pop_front());
    tick();
    total++; if (bus.occupancy !== 4'd4) begin bad++; $display("FAIL sim_push2 got=%0d exp=4", bus.occupancy); end
    for (int i = 0; i < 20; i++) begin
      drive_in(2'b01, 24'(24'h200 + i), 24'h0);
      q.push_back(24'(24'h200 + i));
      total++; if (bus.hit_R19S[0] !== q[0]) begin bad++; $display("FAIL wrap_head%0d got=%0h exp=%0h", i, bus.hit_R19S[0], q[0]); end
      void'(q.pop_front());
      tick();
      if (i == 0) begin
        total++; if (bus.occupancy !== 4'd4) begin bad++; $display("FAIL sim_push1 got=%0d exp=4", bus.occupancy); end
      end
    end
    drive_in(2'b00, 24'h0, 24'h0);
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.hit_R19S[0] !== q[i] || bus.hit_valid_R19H !== 1'b1) begin bad++; $display("FAIL wrap_tail%0d got=%0h exp=%0h", i, bus.hit_R19S[0], q[i]); end
      tick();
    end
    total++; if (bus.hit_valid_R19H !== 1'b0 || bus.occupancy !== 4'd0) begin bad++; $display("FAIL wrap_empty got=%b/%0d exp=0/0", bus.hit_valid_R19H, bus.occupancy); end
  endtask

  task automatic test_lane1_idle();
    bus.out_ready_R19H = 1'b0;
    drive_in(2'b10, 24'h99, 24'h55);
    tick();
    drive_in(2'b00, 24'h66, 24'h66);
    total++; if (bus.occupancy !== 4'd1) begin bad++; $display("FAIL l1_occ got=%0d exp=1", bus.occupancy); end
    total++; if (bus.hit_R19S[0] !== 24'h55) begin bad++; $display("FAIL l1_x got=%0h exp=55", bus.hit_R19S[0]); end
    tick();
    total++; if (bus.occupancy !== 4'd1) begin bad++; $display("FAIL idle_occ got=%0d exp=1", bus.occupancy); end
    total++; if (bus.hit_R19S[0] !== 24'h55) begin bad++; $display("FAIL idle_hold got=%0h exp=55", bus.hit_R19S[0]); end
    bus.out_ready_R19H = 1'b1;
    tick();
    total++; if (bus.occupancy !== 4'd0 || bus.hit_valid_R19H !== 1'b0) begin bad++; $display("FAIL l1_drain got=%0d/%b exp=0/0", bus.occupancy, bus.hit_valid_R19H); end
    tick();
    total++; if (bus.occupancy !== 4'd0) begin bad++; $display("FAIL pop_empty got=%0d exp=0", bus.occupancy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_dual_order();
    test_fill_halt();
    test_boundary7();
    test_simul_wrap();
    test_lane1_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hit_merge_fifo.md
# hit_merge_fifo

Two-lane hit collector sitting directly downstream of the dual-sample test stage (R18). Accepts up to two hit records per cycle (lanes 0 and 1), stores them in order in a small FIFO, and emits one hit per cycle to the framebuffer/Z-update stage with a valid/ready handshake. Backpressure is returned upstream as an active-low halt so no hit is ever dropped.

## Interface
- SIGFIG, 24, bits per position/color component
- AXIS, 3, axes per hit (x,y,z)
- COLORS, 3, color channels
- DEPTH, 8, FIFO entries; power of two, >= 4

- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- hit_R18S  in  [1:0][AXIS-1:0] x SIGFIG signed  per-lane hit position
- color_R18U  in  [1:0][COLORS-1:0] x SIGFIG unsigned  per-lane color
- hit_valid_R18H  in  [1:0] x 1  per-lane hit valid
- halt_RnnnnL  out  1  0 = upstream must hold R18 inputs; 1 = inputs accepted this cycle
- hit_R19S  out  [AXIS-1:0] x SIGFIG signed  head-of-FIFO position
- color_R19U  out  [COLORS-1:0] x SIGFIG unsigned  head-of-FIFO color
- hit_valid_R19H  out  1  head entry valid
- out_ready_R19H  in  1  downstream accepts head this cycle
- occupancy  out  $clog2(DEPTH)+1  current entry count (debug/perf)

## Operation
- Storage: DEPTH-entry circular buffer, write pointer wp, read pointer rp, counter cnt (0..DEPTH); pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
- halt_RnnnnL = (DEPTH - cnt >= 2), combinational from registered cnt only (no path from out_ready_R19H).
- Accept: when halt_RnnnnL=1, push each valid lane; lane 0 written at wp, lane 1 at wp+1 if lane 0 valid, else at wp. Pushes n_in = popcount(hit_valid_R18H) in {0,1,2}. When halt_RnnnnL=0, inputs are ignored entirely (upstream holds them).
- Invalid lanes never occupy an entry; data on invalid lanes is don't-care.
- Pop: when hit_valid_R19H && out_ready_R19H, rp advances by 1, n_out=1.
- Next cnt = cnt + n_in - n_out; push and pop in the same cycle both take effect.
- hit_valid_R19H = (cnt != 0); hit_R19S/color_R19U = storage[rp]; data held stable while valid && !ready.
- No bypass: an entry written at edge N is visible at the output after edge N.
- Order: output order equals arrival order, lane 0 before lane 1 within a cycle.

## Timing
- Reset (rst=0, async): cnt=0, wp=rp=0, hit_valid_R19H=0, halt_RnnnnL=1, occupancy=0; hit_R19S/color_R19U undefined but must not be X-propagating into valid (valid forced 0). Storage contents not reset.
- Reset mid-operation: all entries discarded immediately; first cycle after deassertion behaves as empty.
- Latency: input in cycle N -> hit_valid_R19H=1 in cycle N+1 when empty.
- Throughput: sustained 1 out/cycle; 2 in/cycle until cnt >= DEPTH-1.
- Halt boundary: cnt=DEPTH-2 -> halt=1 (2 slots); cnt=DEPTH-1 or DEPTH -> halt=0, even if a pop occurs that cycle (reassertion follows next cycle from updated cnt).
- Overflow impossible by construction; assertion: cnt never exceeds DEPTH, never underflows.
- Pop while empty: no effect (valid=0 gates pop).

## Test plan
- Reset: drive rst=0 mid-stream with cnt=5 -> immediately hit_valid_R19H=0, occupancy=0, halt_RnnnnL=1; after release, next single push emerges one cycle later.
- Dual-lane order: ready=1, push lane0 x=0x10, lane1 x=0x20 in one cycle, then lane1-only x=0x30 -> output sequence 0x10,0x20,0x30 on consecutive cycles starting one cycle after first push.
- Fill/halt: ready=0, push 2/cycle with DEPTH=8 -> occupancy 2,4,6 then halt_RnnnnL=0 at cnt=6? no: halt stays 1 at cnt=6, push to 8, halt=0 at cnt=8; held inputs not written while halted.
- Boundary 7: ready=0, cnt=7 -> halt=0; assert ready one cycle -> cnt=6, halt=1 next cycle, then a 2-lane push accepted -> cnt=8.
- Simultaneous push/pop: cnt=3, ready=1, push 2 -> cnt=4; push 1 -> cnt stays 4; data order preserved across pointer wrap after 20 entries.
- Lane-1-only and idle: hit_valid_R18H=2'b10 with x=0x55 -> single entry 0x55 written at wp; hit_valid_R18H=2'b00 -> cnt unchanged.
